cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the 5-stage pipelined CPU: holds the 256×16 instruction memory and the 256×16 data memory, answers the CPU's instruction fetch and data load/store ports, and contains a host loader FSM that fills both memories over a valid/ready port. When loading finishes, it starts the CPU. It sits between the testbench/host and the CPU core, on the far end of the CPU's `d_*`/`i_*` buses.

## Interface
- `AW`, 8: address width, for both memories (depth 2^AW).
- `DW`, 16: data width.
- `clock` input 1: clock.
- `reset` input 1: reset, asynchronous, active-low.
- `i_addr` input AW: CPU fetch address (pc).
- `i_rdata` output DW: instruction word to CPU `i_datain`.
- `d_addr` input AW: CPU data address.
- `d_wdata` input DW: CPU store data (`d_dataout`).
- `d_we` input 1: CPU store strobe.
- `d_rdata` output DW: load data to CPU `d_datain`.
- `ld_valid` input 1: host beat valid.
- `ld_ready` output 1: responder accepts beat.
- `ld_sel` input 1: 0 = instruction memory, 1 = data memory.
- `ld_addr` input AW: target address of beat.
- `ld_data` input DW: word to write.
- `ld_last` input 1: final beat of the image.
- `ld_count` output AW+1: accepted beats since the last IDLE→LOAD transition.
- `ld_csum` output DW: checksum of accepted beats (see Configuration).
- `cpu_start` output 1: one-cycle start pulse to CPU (`enable` is tied high externally).
- `cpu_halt` input 1: CPU reports HALT retired.
- `run` output 1: high while the CPU owns memory.

## Operation
- FSM states: IDLE, LOAD, DONE, RUN. Reset state is IDLE.
- IDLE: `ld_ready`=1. An accepted beat (`ld_valid`&&`ld_ready`) does the following:
  - writes the word;
  - clears `ld_count` and `ld_csum`, then counts the beat, so `ld_count`=1;
  - goes to LOAD, or to DONE if `ld_last`=1.
- LOAD: `ld_ready`=1. Each accepted beat does the following:
  - writes `ld_data` into memory[`ld_sel`][`ld_addr`];
  - increments `ld_count` modulo 2^(AW+1);
  - updates `ld_csum`;
  - if `ld_last`=1, goes to DONE.
- DONE: `ld_ready`=0 and `cpu_start`=1 for exactly this cycle. Goes to RUN unconditionally.
- RUN behaviour:
  - `ld_ready`=0 and `run`=1. `ld_valid` is ignored.
  - `cpu_halt`=1 goes to IDLE.
  - `i_rdata` = imem[`i_addr`] and `d_rdata` = dmem[`d_addr`]. Both are combinational reads.
  - `d_we`=1 writes `d_wdata` into dmem[`d_addr`] at the clock edge.
- Outside RUN behaviour:
  - `i_rdata` = 0 (NOP) and `d_rdata` = 0.
  - `d_we` is ignored, so the CPU cannot corrupt memory during load.
- Memory arrays are not cleared by reset. `ld_count` and `ld_csum` hold their values through RUN and IDLE until the next load begins.
- Re-addressing the same location during a load: the last beat written to it wins.

## Timing
- Reset values:
  - `ld_ready`=1, `cpu_start`=0, `run`=0;
  - `ld_count`=0, `ld_csum`=0;
  - `i_rdata`=0, `d_rdata`=0.
  - Reset mid-load or mid-run returns to IDLE immediately. Partially written memory contents remain.
- Loader write latency: the word is visible to the CPU read ports from the first RUN cycle. The earliest RUN is 2 edges after the last beat is accepted (edge 1 → DONE, edge 2 → RUN).
- CPU read latency: 0 cycles (combinational from address).
- CPU write latency: 1 edge.
- Same-cycle read and write to the same dmem address: `d_rdata` shows the old value. The new value appears after the edge.
- `cpu_halt` asserted in the same cycle as the DONE→RUN edge is ignored, because `cpu_halt` is sampled only in RUN.
- `ld_last` together with `ld_valid`=0 has no effect.

## Configuration
- `MEM_LD_CHECKSUM_EN` defined: on each accepted beat, `ld_csum` ← `ld_csum` + `ld_data`, a 16-bit sum modulo 2^16, with carry discarded.
- Not defined: `ld_csum` is constant 0 and no adder is built.

## Test plan
- Reset with `reset`=0, then release → `ld_ready`=1, `run`=0, `cpu_start`=0, `i_rdata`=0, `ld_count`=0.
- Load 3 beats:
  - imem[0]=16'h1234;
  - imem[1]=16'h0800 (HALT);
  - dmem[5]=16'h00FF with `ld_last`=1;
  - expected: `ld_count`=3; `cpu_start` pulses one cycle 1 edge after the last beat; `run`=1 the next cycle; `i_addr`=0 reads 16'h1234; `d_addr`=5 reads 16'h00FF; with `MEM_LD_CHECKSUM_EN`, `ld_csum`=16'h1B33.
- In RUN, `d_we`=1, `d_addr`=5, `d_wdata`=16'hABCD → `d_rdata` is 16'h00FF in the same cycle and 16'hABCD after the edge.
- In LOAD, `d_we`=1 to dmem[7] while beats continue → dmem[7] unchanged in RUN. `ld_valid` asserted in RUN → no write and `ld_count` unchanged.
- `cpu_halt`=1 in RUN → IDLE next edge with `i_rdata`=0 and `ld_ready`=1. A new single beat with `ld_last`=1 → `ld_count`=1 and `ld_csum` restarts from 0.
- Assert `reset`=0 mid-load after 2 beats → IDLE immediately with `ld_count`=0; the already written words are still readable after the next load completes.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: instruction/data memories, CPU fetch/load/store ports, and a host loader FSM.
// Optional load checksum is built only when MEM_LD_CHECKSUM_EN is defined.
module cpu_mem_responder #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_we,
  output logic [DW-1:0] d_rdata,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic [AW:0]   ld_count,
  output logic [DW-1:0] ld_csum,
  output logic          cpu_start,
  input  logic          cpu_halt,
  output logic          run
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_e;

  localparam logic [AW:0] COUNT_ONE = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   ld_count_q, ld_count_d;
  logic          accept;
  logic [DW-1:0] imem_q [2**AW];
  logic [DW-1:0] dmem_q [2**AW];

  assign accept = ld_valid && ld_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ld_last ? DONE : LOAD;
      LOAD:    if (accept && ld_last) state_d = DONE;
      DONE:    state_d = RUN;
      RUN:     if (cpu_halt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = 1'b0;
    cpu_start = 1'b0;
    run       = 1'b0;
    case (state_q)
      IDLE, LOAD: ld_ready  = 1'b1;
      DONE:       cpu_start = 1'b1;
      RUN:        run       = 1'b1;
      default:    ld_ready  = 1'b0;
    endcase
  end

  // The first beat out of IDLE restarts the count rather than accumulating on the previous image.
  always_comb begin
    ld_count_d = ld_count_q;
    if (accept) ld_count_d = (state_q == IDLE) ? COUNT_ONE : ld_count_q + COUNT_ONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ld_count_q <= '0;
    else        ld_count_q <= ld_count_d;
  end

  assign ld_count = ld_count_q;

`ifdef MEM_LD_CHECKSUM_EN
  logic [DW-1:0] ld_csum_q, ld_csum_d;

  always_comb begin
    ld_csum_d = ld_csum_q;
    if (accept) ld_csum_d = (state_q == IDLE) ? ld_data : ld_csum_q + ld_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ld_csum_q <= '0;
    else        ld_csum_q <= ld_csum_d;
  end

  assign ld_csum = ld_csum_q;
`else
  assign ld_csum = '0;
`endif

  // NOTE: the memory arrays have no reset; contents survive reset so a partial image stays readable.
  always_ff @(posedge clock) begin
    if (accept) begin
      if (ld_sel) dmem_q[ld_addr] <= ld_data;
      else        imem_q[ld_addr] <= ld_data;
    end else if (run && d_we) begin
      dmem_q[d_addr] <= d_wdata;
    end
  end

  // Outside RUN the CPU sees NOPs and zero load data.
  assign i_rdata = run ? imem_q[i_addr] : '0;
  assign d_rdata = run ? dmem_q[d_addr] : '0;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: expected values are queued as stimulus is applied
// and popped at each comparison point.
module tb_cpu_mem_responder;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr, d_addr, ld_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, ld_data, ld_csum;
  logic          d_we, ld_valid, ld_ready, ld_sel, ld_last, cpu_start, cpu_halt, run;
  logic [AW:0]   ld_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];

  always #5 clock = ~clock;

  cpu_mem_responder #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .i_addr(i_addr), .i_rdata(i_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_rdata(d_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .ld_count(ld_count), .ld_csum(ld_csum),
    .cpu_start(cpu_start), .cpu_halt(cpu_halt), .run(run)
  );

  function automatic logic [31:0] csum_exp(input logic [15:0] sum);
`ifdef MEM_LD_CHECKSUM_EN
    return {16'h0, sum};
`else
    return 32'h0;
`endif
  endfunction

  task automatic push(input logic [31:0] exp);
    sb.push_back(exp);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Present one beat just after a falling edge; returns just after the next falling edge.
  task automatic beat(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic last);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data; ld_last = last;
    @(negedge clock);
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0; cpu_halt = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    push(1); push(0); push(0); push(0); push(0); push(0); push(0);
    check("rst_ld_ready", 32'(ld_ready));
    check("rst_run", 32'(run));
    check("rst_cpu_start", 32'(cpu_start));
    check("rst_i_rdata", 32'(i_rdata));
    check("rst_d_rdata", 32'(d_rdata));
    check("rst_ld_count", 32'(ld_count));
    check("rst_ld_csum", 32'(ld_csum));

    // Three-beat image; the beat that carries ld_last moves the FSM to DONE.
    beat(1'b0, 8'd0, 16'h1234, 1'b0);
    beat(1'b0, 8'd1, 16'h0800, 1'b0);
    beat(1'b1, 8'd5, 16'h00FF, 1'b1);
    push(1); push(0); push(0); push(3); push(csum_exp(16'h1B33));
    check("done_cpu_start", 32'(cpu_start));
    check("done_ld_ready", 32'(ld_ready));
    check("done_run", 32'(run));
    check("done_ld_count", 32'(ld_count));
    check("done_ld_csum", 32'(ld_csum));

    // Halt during DONE must be ignored.
    cpu_halt = 1'b1;
    @(negedge clock);
    cpu_halt = 1'b0; i_addr = 8'd0; d_addr = 8'd5;
    #1;
    push(1); push(0); push(16'h1234); push(16'h00FF);
    check("run_run", 32'(run));
    check("run_cpu_start", 32'(cpu_start));
    check("run_imem0", 32'(i_rdata));
    check("run_dmem5", 32'(d_rdata));
    i_addr = 8'd1;
    #1;
    push(16'h0800);
    check("run_imem1", 32'(i_rdata));

    // CPU store: old value visible before the edge, new value after.
    d_we = 1'b1; d_addr = 8'd5; d_wdata = 16'hABCD;
    #1;
    push(16'h00FF);
    check("st_same_cycle", 32'(d_rdata));
    @(negedge clock);
    d_we = 1'b0;
    #1;
    push(16'hABCD);
    check("st_after_edge", 32'(d_rdata));

    // Loader beats while running are refused.
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'd5; ld_data = 16'h1111; ld_last = 1'b1;
    #1;
    push(0);
    check("run_ld_ready", 32'(ld_ready));
    @(negedge clock);
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    push(1); push(3); push(16'hABCD);
    check("run_ign_run", 32'(run));
    check("run_ign_count", 32'(ld_count));
    check("run_ign_dmem5", 32'(d_rdata));

    // Halt returns to IDLE; reads go to zero, counters hold.
    cpu_halt = 1'b1; i_addr = 8'd0;
    @(negedge clock);
    cpu_halt = 1'b0;
    #1;
    push(0); push(1); push(0); push(0); push(3);
    check("halt_run", 32'(run));
    check("halt_ld_ready", 32'(ld_ready));
    check("halt_i_rdata", 32'(i_rdata));
    check("halt_d_rdata", 32'(d_rdata));
    check("halt_ld_count", 32'(ld_count));

    // Store strobe in IDLE must not reach memory; then a single-beat image.
    d_we = 1'b1; d_addr = 8'd5; d_wdata = 16'h5555;
    @(negedge clock);
    d_we = 1'b0;
    beat(1'b0, 8'd3, 16'h00AA, 1'b1);
    push(1); push(csum_exp(16'h00AA)); push(1);
    check("single_ld_count", 32'(ld_count));
    check("single_ld_csum", 32'(ld_csum));
    check("single_cpu_start", 32'(cpu_start));
    @(negedge clock);
    d_addr = 8'd5; i_addr = 8'd3;
    #1;
    push(16'hABCD); push(16'h00AA);
    check("idle_we_ignored", 32'(d_rdata));
    check("single_imem3", 32'(i_rdata));
    cpu_halt = 1'b1;
    @(negedge clock);
    cpu_halt = 1'b0;
    #1;

    // Two beats with a concurrent CPU store, then reset mid-load.
    beat(1'b1, 8'd7, 16'h7777, 1'b0);
    d_we = 1'b1; d_addr = 8'd7; d_wdata = 16'hDEAD;
    beat(1'b0, 8'd4, 16'h4444, 1'b0);
    push(2); push(0);
    check("mid_ld_count", 32'(ld_count));
    check("mid_run", 32'(run));
    reset = 1'b0;
    #1;
    push(0); push(1); push(0);
    check("rst_mid_count", 32'(ld_count));
    check("rst_mid_ready", 32'(ld_ready));
    check("rst_mid_csum", 32'(ld_csum));
    d_we = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // ld_last without ld_valid does nothing.
    ld_last = 1'b1;
    @(negedge clock);
    ld_last = 1'b0;
    #1;
    push(0); push(0);
    check("lastonly_cpu_start", 32'(cpu_start));
    check("lastonly_count", 32'(ld_count));

    beat(1'b1, 8'd8, 16'h0008, 1'b1);
    push(1);
    check("reload_count", 32'(ld_count));
    @(negedge clock);
    d_addr = 8'd7; i_addr = 8'd4;
    #1;
    push(1); push(16'h7777); push(16'h4444);
    check("reload_run", 32'(run));
    check("reload_dmem7", 32'(d_rdata));
    check("reload_imem4", 32'(i_rdata));
    d_addr = 8'd8; i_addr = 8'd0;
    #1;
    push(16'h0008); push(16'h1234);
    check("reload_dmem8", 32'(d_rdata));
    check("reload_imem0", 32'(i_rdata));

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d leftover expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
